// File: rtl/multicycle_controller_if.sv
// Control/status bundle between the multicycle sequencer (master) and the RV32I datapath (slave).
interface multicycle_controller_if #(
  parameter int OP_WIDTH = 4
);
  logic [31:0]         inst;
  logic                br_eq;
  logic                br_lt;
  logic                mem_ready;
  logic                ir_we;
  logic                pc_we;
  logic                pcmux_sel;
  logic                regfile_we;
  logic [2:0]          imm_sel;
  logic                cmpop;
  logic                alumux1_sel;
  logic                alumux2_sel;
  logic [OP_WIDTH-1:0] aluop;
  logic                dmem_re;
  logic                dmem_we;
  logic [1:0]          wbmux_sel;
  logic                retire;
  logic                trap;
  logic [1:0]          trap_cause;

  modport master (
    input  inst, br_eq, br_lt, mem_ready,
    output ir_we, pc_we, pcmux_sel, regfile_we, imm_sel, cmpop, alumux1_sel,
           alumux2_sel, aluop, dmem_re, dmem_we, wbmux_sel, retire, trap, trap_cause
  );

  modport slave (
    output inst, br_eq, br_lt, mem_ready,
    input  ir_we, pc_we, pcmux_sel, regfile_we, imm_sel, cmpop, alumux1_sel,
           alumux2_sel, aluop, dmem_re, dmem_we, wbmux_sel, retire, trap, trap_cause
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with registered enables,
// inst-decoded selects, bounded dmem wait and a sticky trap.
module multicycle_controller #(
  parameter int OP_WIDTH    = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input logic                     clk,
  input logic                     reset,
  multicycle_controller_if.master bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [OP_WIDTH-1:0] ALU_ADD    = OP_WIDTH'(0);
  localparam logic [OP_WIDTH-1:0] ALU_SUB    = OP_WIDTH'(1);
  localparam logic [OP_WIDTH-1:0] ALU_SLL    = OP_WIDTH'(2);
  localparam logic [OP_WIDTH-1:0] ALU_SLT    = OP_WIDTH'(3);
  localparam logic [OP_WIDTH-1:0] ALU_SLTU   = OP_WIDTH'(4);
  localparam logic [OP_WIDTH-1:0] ALU_XOR    = OP_WIDTH'(5);
  localparam logic [OP_WIDTH-1:0] ALU_SRL    = OP_WIDTH'(6);
  localparam logic [OP_WIDTH-1:0] ALU_SRA    = OP_WIDTH'(7);
  localparam logic [OP_WIDTH-1:0] ALU_OR     = OP_WIDTH'(8);
  localparam logic [OP_WIDTH-1:0] ALU_AND    = OP_WIDTH'(9);
  localparam logic [OP_WIDTH-1:0] ALU_PASS_B = OP_WIDTH'(10);

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

  localparam int                CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ir_we_q;
  logic             pc_we_q;
  logic             regfile_we_q;
  logic             dmem_re_q;
  logic             dmem_we_q;
  logic             retire_q;
  logic             trap_q;
  logic [1:0]       cause_q;

  // Instruction fields
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b5;
  logic       rd_nz;
  logic       unused_inst;

  assign opcode      = bus.inst[6:0];
  assign funct3      = bus.inst[14:12];
  assign funct7_b5   = bus.inst[30];
  assign rd_nz       = (bus.inst[11:7] != 5'd0);
  assign unused_inst = ^{bus.inst[31], bus.inst[29:15]};

  logic is_load;
  logic is_store;
  logic is_branch;
  logic illegal;

  assign is_load   = (opcode == OPC_LOAD);
  assign is_store  = (opcode == OPC_STORE);
  assign is_branch = (opcode == OPC_BRANCH);

  always_comb begin
    illegal = 1'b1;
    case (opcode)
      OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC, OPC_JAL: illegal = 1'b0;
      OPC_LOAD, OPC_STORE:                            illegal = (funct3 != 3'b010);
      OPC_BRANCH:                                     illegal = (funct3[2:1] == 2'b01);
      OPC_JALR:                                       illegal = (funct3 != 3'b000);
      default:                                        illegal = 1'b1;
    endcase
  end

  // Register-register SUB is the only subtract; SRA/SRAI share funct7[5]
  logic [OP_WIDTH-1:0] alu_funct;

  always_comb begin
    alu_funct = ALU_ADD;
    case (funct3)
      3'b000:  alu_funct = ((opcode == OPC_OP) && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_funct = ALU_SLL;
      3'b010:  alu_funct = ALU_SLT;
      3'b011:  alu_funct = ALU_SLTU;
      3'b100:  alu_funct = ALU_XOR;
      3'b101:  alu_funct = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_funct = ALU_OR;
      default: alu_funct = ALU_AND;
    endcase
  end

  // funct3[0] inverts the sense (BNE/BGE/BGEU), funct3[2] picks lt over eq
  logic br_taken;
  assign br_taken = funct3[2] ? (bus.br_lt ^ funct3[0]) : (bus.br_eq ^ funct3[0]);

  logic [2:0]          imm_sel_w;
  logic                cmpop_w;
  logic                alumux1_w;
  logic                alumux2_w;
  logic [OP_WIDTH-1:0] aluop_w;
  logic [1:0]          wbmux_w;
  logic                pcmux_w;

  always_comb begin
    imm_sel_w = IMM_I;
    cmpop_w   = 1'b0;
    alumux1_w = 1'b0;
    alumux2_w = 1'b1;
    aluop_w   = ALU_ADD;
    wbmux_w   = WB_ALU;
    pcmux_w   = 1'b0;
    case (opcode)
      OPC_OP: begin
        alumux2_w = 1'b0;
        aluop_w   = alu_funct;
      end
      OPC_OPIMM: aluop_w = alu_funct;
      OPC_LUI: begin
        imm_sel_w = IMM_U;
        aluop_w   = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        imm_sel_w = IMM_U;
        alumux1_w = 1'b1;
      end
      OPC_LOAD:  wbmux_w = WB_MEM;
      OPC_STORE: imm_sel_w = IMM_S;
      OPC_BRANCH: begin
        imm_sel_w = IMM_B;
        alumux1_w = 1'b1;
        cmpop_w   = funct3[1];
        pcmux_w   = br_taken;
      end
      OPC_JAL: begin
        imm_sel_w = IMM_J;
        alumux1_w = 1'b1;
        wbmux_w   = WB_PC4;
        pcmux_w   = 1'b1;
      end
      OPC_JALR: begin
        wbmux_w = WB_PC4;
        pcmux_w = 1'b1;
      end
      default: ;
    endcase
  end

  // Enables are registered for the state being entered, so they read as Moore outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_FETCH;
      cnt_q        <= '0;
      trap_q       <= 1'b0;
      cause_q      <= CAUSE_NONE;
      ir_we_q      <= 1'b1;
      pc_we_q      <= 1'b0;
      regfile_we_q <= 1'b0;
      dmem_re_q    <= 1'b0;
      dmem_we_q    <= 1'b0;
      retire_q     <= 1'b0;
    end else begin
      ir_we_q      <= 1'b0;
      pc_we_q      <= 1'b0;
      regfile_we_q <= 1'b0;
      dmem_re_q    <= 1'b0;
      dmem_we_q    <= 1'b0;
      retire_q     <= 1'b0;
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          if (illegal) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_ILLEGAL;
          end else begin
            state_q <= S_EXEC;
            if (is_branch) begin
              pc_we_q  <= 1'b1;
              retire_q <= 1'b1;
            end
          end
        end
        S_EXEC: begin
          if (is_branch) begin
            state_q <= S_FETCH;
            ir_we_q <= 1'b1;
          end else if (is_load || is_store) begin
            state_q   <= S_MEM;
            cnt_q     <= '0;
            dmem_re_q <= is_load;
            dmem_we_q <= is_store;
          end else begin
            state_q      <= S_WB;
            regfile_we_q <= rd_nz;
            pc_we_q      <= 1'b1;
            retire_q     <= 1'b1;
          end
        end
        S_MEM: begin
          if (bus.mem_ready) begin
            if (dmem_we_q) begin
              state_q <= S_FETCH;
              ir_we_q <= 1'b1;
            end else begin
              state_q      <= S_WB;
              regfile_we_q <= rd_nz;
              pc_we_q      <= 1'b1;
              retire_q     <= 1'b1;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_q <= S_TRAP;
            trap_q  <= 1'b1;
            cause_q <= CAUSE_TIMEOUT;
          end else begin
            cnt_q     <= cnt_q + CNT_W'(1);
            dmem_re_q <= dmem_re_q;
            dmem_we_q <= dmem_we_q;
          end
        end
        S_WB: begin
          state_q <= S_FETCH;
          ir_we_q <= 1'b1;
        end
        S_TRAP:  state_q <= S_TRAP;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // A store retires in the same cycle its handshake completes
  logic store_done;
  assign store_done = (state_q == S_MEM) && dmem_we_q && bus.mem_ready;

  assign bus.ir_we       = ir_we_q & reset;
  assign bus.pc_we       = (pc_we_q | store_done) & reset;
  assign bus.regfile_we  = regfile_we_q & reset;
  assign bus.dmem_re     = dmem_re_q & reset;
  assign bus.dmem_we     = dmem_we_q & reset;
  assign bus.retire      = (retire_q | store_done) & reset;
  assign bus.trap        = trap_q;
  assign bus.trap_cause  = cause_q;
  assign bus.imm_sel     = imm_sel_w;
  assign bus.cmpop       = cmpop_w;
  assign bus.alumux1_sel = alumux1_w;
  assign bus.alumux2_sel = alumux2_w;
  assign bus.aluop       = aluop_w;
  assign bus.wbmux_sel   = wbmux_w;
  assign bus.pcmux_sel   = pcmux_w;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle expected enable/trap vectors
// are queued per instruction and popped as the DUT steps.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  multicycle_controller_if #(.OP_WIDTH(4)) dp_if ();

  multicycle_controller #(.OP_WIDTH(4), .MEM_TIMEOUT(15)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (dp_if)
  );

  int total = 0;
  int bad   = 0;

  // {ir_we, pc_we, regfile_we, dmem_re, dmem_we, retire, trap, trap_cause}
  logic [8:0] obs;
  assign obs = {dp_if.ir_we, dp_if.pc_we, dp_if.regfile_we, dp_if.dmem_re, dp_if.dmem_we,
                dp_if.retire, dp_if.trap, dp_if.trap_cause};

  localparam logic [8:0] E_IDLE     = 9'b000000_0_00;
  localparam logic [8:0] E_FETCH    = 9'b100000_0_00;
  localparam logic [8:0] E_WB       = 9'b011001_0_00;
  localparam logic [8:0] E_WB_X0    = 9'b010001_0_00;
  localparam logic [8:0] E_BR       = 9'b010001_0_00;
  localparam logic [8:0] E_LD       = 9'b000100_0_00;
  localparam logic [8:0] E_ST       = 9'b000010_0_00;
  localparam logic [8:0] E_ST_DONE  = 9'b010011_0_00;
  localparam logic [8:0] E_TRAP_MEM = 9'b000000_1_10;
  localparam logic [8:0] E_TRAP_ILL = 9'b000000_1_01;

  localparam logic [31:0] I_ADD    = 32'h002081B3;
  localparam logic [31:0] I_ADD_X0 = 32'h00208033;
  localparam logic [31:0] I_LW     = 32'h0000A183;
  localparam logic [31:0] I_SW     = 32'h0020A023;
  localparam logic [31:0] I_JAL    = 32'h010000EF;
  localparam logic [31:0] I_JALR   = 32'h000100E7;

  localparam logic [31:0] BR_INST [4] = '{32'h00208463, 32'h00208463, 32'h0020E463, 32'h0020D463};
  localparam logic        BR_EQ   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  localparam logic        BR_LT   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic        BR_TAKE [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  localparam logic        BR_CMP  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};

  localparam logic [31:0] ILL_INST [4] = '{32'h00000000, 32'h00008183, 32'h0020A463, 32'h000110E7};

  localparam int          BB_N = 7;
  localparam logic [31:0] BB_INST [BB_N] = '{32'h402081B3, 32'h123452B7, 32'h4030D193, 32'h40008193,
                                             32'h00001197, 32'h0020B1B3, 32'h0050C193};
  localparam logic [3:0]  BB_ALU  [BB_N] = '{4'd1, 4'd10, 4'd7, 4'd0, 4'd0, 4'd4, 4'd5};
  localparam logic        BB_M1   [BB_N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  localparam logic        BB_M2   [BB_N] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  localparam logic [2:0]  BB_IMM  [BB_N] = '{3'd0, 3'd3, 3'd0, 3'd0, 3'd3, 3'd0, 3'd0};

  typedef struct packed {
    logic [31:0] inst;
    logic [3:0]  aluop;
    logic        m1;
    logic        m2;
    logic [2:0]  imm;
  } sel_t;

  logic [8:0] exp_q[$];
  sel_t       sb_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in the first FETCH cycle with reset released
  task automatic do_reset(input logic [31:0] i);
    reset           = 1'b0;
    dp_if.inst      = i;
    dp_if.br_eq     = 1'b0;
    dp_if.br_lt     = 1'b0;
    dp_if.mem_ready = 1'b0;
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset           = 1'b0;
    dp_if.inst      = I_ADD;
    dp_if.br_eq     = 1'b0;
    dp_if.br_lt     = 1'b0;
    dp_if.mem_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      total++;
      if (obs !== E_IDLE) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b exp=%b", c, obs, E_IDLE);
      end
    end
    reset = 1'b1;
    #1;
    total++;
    if (obs !== E_FETCH) begin
      bad++;
      $display("FAIL reset_release got=%b exp=%b", obs, E_FETCH);
    end
    $display("reset: enables low while held, FETCH on release");
  endtask

  task automatic test_add();
    logic [8:0] e;
    do_reset(I_ADD);
    exp_q.push_back(E_FETCH);
    exp_q.push_back(E_IDLE);
    exp_q.push_back(E_IDLE);
    exp_q.push_back(E_WB);
    exp_q.push_back(E_FETCH);
    for (int c = 1; exp_q.size() > 0; c++) begin
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL add_en cyc=%0d got=%b exp=%b", c, obs, e);
      end
      if (c >= 2 && c <= 4) begin
        total++;
        if ({dp_if.aluop, dp_if.alumux1_sel, dp_if.alumux2_sel} !== 6'b0000_00) begin
          bad++;
          $display("FAIL add_sel cyc=%0d got=%h/%b/%b exp=0/0/0", c, dp_if.aluop,
                   dp_if.alumux1_sel, dp_if.alumux2_sel);
        end
      end
      if (c == 4) begin
        total++;
        if ({dp_if.wbmux_sel, dp_if.pcmux_sel} !== 3'b01_0) begin
          bad++;
          $display("FAIL add_wb got=wb%0d/pc%b exp=wb1/pc0", dp_if.wbmux_sel, dp_if.pcmux_sel);
        end
      end
      tick();
    end
    $display("add x3,x1,x2: 4-cycle sequence checked");
  endtask

  task automatic test_branch();
    logic [8:0] e;
    for (int k = 0; k < 4; k++) begin
      do_reset(BR_INST[k]);
      dp_if.br_eq = BR_EQ[k];
      dp_if.br_lt = BR_LT[k];
      #1;
      exp_q.push_back(E_FETCH);
      exp_q.push_back(E_IDLE);
      exp_q.push_back(E_BR);
      exp_q.push_back(E_FETCH);
      for (int c = 1; exp_q.size() > 0; c++) begin
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL br%0d_en cyc=%0d got=%b exp=%b", k, c, obs, e);
        end
        if (c == 3) begin
          total++;
          if ({dp_if.pcmux_sel, dp_if.cmpop, dp_if.imm_sel, dp_if.alumux1_sel, dp_if.alumux2_sel,
               dp_if.aluop} !== {BR_TAKE[k], BR_CMP[k], 3'd2, 2'b11, 4'd0}) begin
            bad++;
            $display("FAIL br%0d_sel got=pc%b cmp%b imm%0d m%b%b op%0d exp=pc%b cmp%b imm2 m11 op0",
                     k, dp_if.pcmux_sel, dp_if.cmpop, dp_if.imm_sel, dp_if.alumux1_sel,
                     dp_if.alumux2_sel, dp_if.aluop, BR_TAKE[k], BR_CMP[k]);
          end
        end
        tick();
      end
      $display("branch %h eq=%b lt=%b: taken=%b checked", BR_INST[k], BR_EQ[k], BR_LT[k], BR_TAKE[k]);
    end
    dp_if.br_eq = 1'b0;
    dp_if.br_lt = 1'b0;
  endtask

  task automatic test_load();
    logic [8:0] e;
    do_reset(I_LW);
    exp_q.push_back(E_FETCH);
    exp_q.push_back(E_IDLE);
    exp_q.push_back(E_IDLE);
    for (int w = 0; w < 4; w++) exp_q.push_back(E_LD);
    exp_q.push_back(E_WB);
    exp_q.push_back(E_FETCH);
    for (int c = 1; exp_q.size() > 0; c++) begin
      // early mem_ready outside MEM must be ignored
      dp_if.mem_ready = (c <= 3) || (c == 7);
      #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL lw_en cyc=%0d got=%b exp=%b", c, obs, e);
      end
      if (c == 8) begin
        total++;
        if (dp_if.wbmux_sel !== 2'd0) begin
          bad++;
          $display("FAIL lw_wbmux got=%0d exp=0", dp_if.wbmux_sel);
        end
      end
      tick();
    end
    dp_if.mem_ready = 1'b0;
    $display("lw x3,0(x1): 3 wait cycles, 8 cycles checked");
  endtask

  task automatic test_store_boundary();
    logic [8:0] e;
    do_reset(I_SW);
    exp_q.push_back(E_FETCH);
    exp_q.push_back(E_IDLE);
    exp_q.push_back(E_IDLE);
    for (int w = 0; w < 14; w++) exp_q.push_back(E_ST);
    exp_q.push_back(E_ST_DONE);
    exp_q.push_back(E_FETCH);
    for (int c = 1; exp_q.size() > 0; c++) begin
      dp_if.mem_ready = (c == 18);
      #1;
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL sw_last_en cyc=%0d got=%b exp=%b", c, obs, e);
      end
      if (c == 18) begin
        total++;
        if (dp_if.pcmux_sel !== 1'b0) begin
          bad++;
          $display("FAIL sw_last_pcmux got=%b exp=0", dp_if.pcmux_sel);
        end
      end
      tick();
    end
    dp_if.mem_ready = 1'b0;
    $display("sw: mem_ready on 15th MEM cycle completes");
  endtask

  task automatic test_store_timeout();
    logic [8:0] e;
    do_reset(I_SW);
    exp_q.push_back(E_FETCH);
    exp_q.push_back(E_IDLE);
    exp_q.push_back(E_IDLE);
    for (int w = 0; w < 15; w++) exp_q.push_back(E_ST);
    for (int w = 0; w < 4; w++) exp_q.push_back(E_TRAP_MEM);
    for (int c = 1; exp_q.size() > 0; c++) begin
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL sw_timeout_en cyc=%0d got=%b exp=%b", c, obs, e);
      end
      tick();
    end
    reset = 1'b0;
    tick();
    total++;
    if (obs !== E_IDLE) begin
      bad++;
      $display("FAIL trap_clear got=%b exp=%b", obs, E_IDLE);
    end
    reset = 1'b1;
    #1;
    total++;
    if (obs !== E_FETCH) begin
      bad++;
      $display("FAIL trap_refetch got=%b exp=%b", obs, E_FETCH);
    end
    $display("sw: timeout trap cause 2, cleared by reset");
  endtask

  task automatic test_illegal();
    logic [8:0] e;
    for (int k = 0; k < 4; k++) begin
      do_reset(ILL_INST[k]);
      exp_q.push_back(E_FETCH);
      exp_q.push_back(E_IDLE);
      for (int w = 0; w < 22; w++) exp_q.push_back(E_TRAP_ILL);
      for (int c = 1; exp_q.size() > 0; c++) begin
        // mem_ready in TRAP must not revive anything
        dp_if.mem_ready = c[0];
        #1;
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL illegal%0d_en cyc=%0d got=%b exp=%b", k, c, obs, e);
        end
        tick();
      end
      dp_if.mem_ready = 1'b0;
      $display("illegal %h: trap cause 1 held", ILL_INST[k]);
    end
  endtask

  task automatic test_x0();
    logic [8:0] e;
    do_reset(I_ADD_X0);
    exp_q.push_back(E_FETCH);
    exp_q.push_back(E_IDLE);
    exp_q.push_back(E_IDLE);
    exp_q.push_back(E_WB_X0);
    exp_q.push_back(E_FETCH);
    for (int c = 1; exp_q.size() > 0; c++) begin
      e = exp_q.pop_front();
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL x0_en cyc=%0d got=%b exp=%b", c, obs, e);
      end
      tick();
    end
    $display("add x0,x1,x2: regfile write suppressed");
  endtask

  task automatic test_jump();
    logic [8:0]  e;
    logic [31:0] ji;
    logic [2:0]  jimm;
    logic        jm1;
    for (int k = 0; k < 2; k++) begin
      ji   = (k == 0) ? I_JAL : I_JALR;
      jimm = (k == 0) ? 3'd4 : 3'd0;
      jm1  = (k == 0);
      do_reset(ji);
      exp_q.push_back(E_FETCH);
      exp_q.push_back(E_IDLE);
      exp_q.push_back(E_IDLE);
      exp_q.push_back(E_WB);
      exp_q.push_back(E_FETCH);
      for (int c = 1; exp_q.size() > 0; c++) begin
        e = exp_q.pop_front();
        total++;
        if (obs !== e) begin
          bad++;
          $display("FAIL jump%0d_en cyc=%0d got=%b exp=%b", k, c, obs, e);
        end
        if (c == 4) begin
          total++;
          if ({dp_if.pcmux_sel, dp_if.wbmux_sel, dp_if.imm_sel, dp_if.alumux1_sel,
               dp_if.alumux2_sel, dp_if.aluop} !== {1'b1, 2'd2, jimm, jm1, 1'b1, 4'd0}) begin
            bad++;
            $display("FAIL jump%0d_sel got=pc%b wb%0d imm%0d m%b%b op%0d exp=pc1 wb2 imm%0d m%b1 op0",
                     k, dp_if.pcmux_sel, dp_if.wbmux_sel, dp_if.imm_sel, dp_if.alumux1_sel,
                     dp_if.alumux2_sel, dp_if.aluop, jimm, jm1);
          end
        end
        tick();
      end
      $display("jump %h: link writeback and pc load checked", ji);
    end
  endtask

  task automatic test_back_to_back();
    sel_t got_rec;
    sel_t exp_rec;
    do_reset(BB_INST[0]);
    for (int n = 0; n < BB_N; n++) begin
      dp_if.inst = BB_INST[n];
      sb_q.push_back('{inst: BB_INST[n], aluop: BB_ALU[n], m1: BB_M1[n], m2: BB_M2[n], imm: BB_IMM[n]});
      for (int c = 1; c <= 4; c++) begin
        #1;
        total++;
        if (obs !== ((c == 1) ? E_FETCH : (c == 4) ? E_WB : E_IDLE)) begin
          bad++;
          $display("FAIL b2b%0d_en cyc=%0d got=%b", n, c, obs);
        end
        if (dp_if.retire === 1'b1) begin
          total++;
          if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL b2b_retire_extra inst=%h got=retire exp=none", dp_if.inst);
          end else begin
            exp_rec = sb_q.pop_front();
            got_rec = '{inst: dp_if.inst, aluop: dp_if.aluop, m1: dp_if.alumux1_sel,
                        m2: dp_if.alumux2_sel, imm: exp_rec.m2 ? dp_if.imm_sel : exp_rec.imm};
            if (got_rec !== exp_rec) begin
              bad++;
              $display("FAIL b2b_sel inst=%h got=op%0d m%b%b imm%0d exp=op%0d m%b%b imm%0d",
                       exp_rec.inst, got_rec.aluop, got_rec.m1, got_rec.m2, got_rec.imm,
                       exp_rec.aluop, exp_rec.m1, exp_rec.m2, exp_rec.imm);
            end
          end
        end
        tick();
      end
      $display("b2b %h retired", BB_INST[n]);
    end
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL b2b_missing_retire got=%0d pending exp=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset(I_LW);
    for (int c = 1; c < 5; c++) tick();
    total++;
    if (obs !== E_LD) begin
      bad++;
      $display("FAIL midrst_mem got=%b exp=%b", obs, E_LD);
    end
    reset = 1'b0;
    tick();
    total++;
    if (obs !== E_IDLE) begin
      bad++;
      $display("FAIL midrst_abort got=%b exp=%b", obs, E_IDLE);
    end
    reset = 1'b1;
    #1;
    total++;
    if (obs !== E_FETCH) begin
      bad++;
      $display("FAIL midrst_fetch got=%b exp=%b", obs, E_FETCH);
    end
    tick();
    total++;
    if (obs !== E_IDLE) begin
      bad++;
      $display("FAIL midrst_decode got=%b exp=%b", obs, E_IDLE);
    end
    $display("lw aborted by reset in MEM, refetch checked");
  endtask

  initial begin
    dp_if.inst      = 32'h0;
    dp_if.br_eq     = 1'b0;
    dp_if.br_lt     = 1'b0;
    dp_if.mem_ready = 1'b0;
    test_reset();
    test_add();
    test_branch();
    test_load();
    test_store_boundary();
    test_store_timeout();
    test_illegal();
    test_x0();
    test_jump();
    test_back_to_back();
    test_reset_mid_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
